// File: rtl/led_fade.sv
// led_fade: turns the blink gate into linear PWM brightness ramps (fade in/out).
// Optional square-law duty mapping is enabled with `define LED_FADE_GAMMA_EN.
module led_fade #(
    parameter int pwm_bits_g = 4,
    parameter int step_div_g = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i,
    output logic                  o,
    output logic [pwm_bits_g-1:0] level,
    output logic                  busy
);

    localparam int N  = pwm_bits_g;
    localparam int PW = (step_div_g > 1) ? $clog2(step_div_g) : 1;
    localparam logic [N-1:0]  LVL_MAX  = {N{1'b1}};
    localparam logic [N-1:0]  LVL_ZERO = {N{1'b0}};
    localparam logic [N-1:0]  LVL_ONE  = N'(1);
    localparam logic [PW-1:0] PS_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] PS_ONE   = PW'(1);
    localparam logic [PW-1:0] PS_LAST  = PW'(step_div_g - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          i_q;
    logic [N-1:0]  level_q, level_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [N-1:0]  pwm_cnt_q;
    logic          o_q, o_d;
    logic          busy_q, busy_d;
    logic [N-1:0]  level_eff_s;
    logic          tick_s;

`ifdef LED_FADE_GAMMA_EN
    logic [2*N-1:0] gamma_s;

    // Square-law duty: top half of level^2 keeps the curve within 0..MAX.
    always_comb begin
        gamma_s     = {{N{1'b0}}, level_q} * {{N{1'b0}}, level_q};
        level_eff_s = gamma_s[2*N-1:N];
    end
`else
    // Linear duty mapping.
    always_comb begin
        level_eff_s = level_q;
    end
`endif

    // Step tick when the prescaler reaches its last count.
    always_comb begin
        tick_s = (presc_q == PS_LAST);
    end

    // Next-state, brightness stepping and PWM compare.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        presc_d = tick_s ? PS_ZERO : (presc_q + PS_ONE);
        case (state_q)
            ST_OFF: begin
                if (i_q) begin
                    state_d = ST_UP;
                    presc_d = PS_ZERO;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_UP: begin
                // A reversal takes priority over a step so the level never jumps.
                if (!i_q) begin
                    state_d = ST_DOWN;
                    presc_d = PS_ZERO;
                end else if (tick_s) begin
                    if (level_q >= (LVL_MAX - LVL_ONE)) begin
                        level_d = LVL_MAX;
                        state_d = ST_ON;
                    end else begin
                        level_d = level_q + LVL_ONE;
                    end
                end else begin
                    level_d = level_q;
                end
            end
            ST_ON: begin
                if (!i_q) begin
                    state_d = ST_DOWN;
                    presc_d = PS_ZERO;
                end else begin
                    state_d = ST_ON;
                end
            end
            ST_DOWN: begin
                if (i_q) begin
                    state_d = ST_UP;
                    presc_d = PS_ZERO;
                end else if (tick_s) begin
                    if (level_q <= LVL_ONE) begin
                        level_d = LVL_ZERO;
                        state_d = ST_OFF;
                    end else begin
                        level_d = level_q - LVL_ONE;
                    end
                end else begin
                    level_d = level_q;
                end
            end
            default: begin
                state_d = ST_OFF;
                level_d = LVL_ZERO;
                presc_d = PS_ZERO;
            end
        endcase
        busy_d = (state_d == ST_UP) || (state_d == ST_DOWN);
        o_d    = (level_q == LVL_MAX) ? 1'b1 : (pwm_cnt_q < level_eff_s);
    end

    // State, level, prescaler, PWM counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OFF;
            i_q       <= 1'b0;
            level_q   <= LVL_ZERO;
            presc_q   <= PS_ZERO;
            pwm_cnt_q <= LVL_ZERO;
            o_q       <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i;
            level_q   <= level_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_q + LVL_ONE;
            o_q       <= o_d;
            busy_q    <= busy_d;
        end
    end

    assign o     = o_q;
    assign level = level_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_led_fade.sv
// tb_led_fade: scoreboard bench for led_fade (N=4, step 2) plus a slow
// instance (step 64) used for PWM duty measurement.
module tb_led_fade;

    localparam int SEL_LEVEL = 0;
    localparam int SEL_BUSY  = 1;
    localparam int SEL_O     = 2;

    logic       clk;
    logic       rst_n;
    logic       i;
    logic       o;
    logic [3:0] level;
    logic       busy;

    logic       rst_n_s;
    logic       i_s;
    logic       o_s;
    logic [3:0] level_s;
    logic       busy_s;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string tag;
    } exp_t;

    exp_t sb_q[$];

    led_fade #(.pwm_bits_g(4), .step_div_g(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .i(i), .o(o), .level(level), .busy(busy)
    );

    led_fade #(.pwm_bits_g(4), .step_div_g(64)) u_slow (
        .clk(clk), .rst_n(rst_n_s), .i(i_s), .o(o_s), .level(level_s), .busy(busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index: at the negedge after edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, act, exp);
        end
    endtask

    function automatic int obs(input int sel);
        case (sel)
            SEL_LEVEL: obs = int'(level);
            SEL_BUSY:  obs = int'(busy);
            SEL_O:     obs = int'(o);
            default:   obs = -1;
        endcase
    endfunction

    task automatic push(input int c, input int sel, input int val, input string tag);
        exp_t e;
        int   k;
        e.cyc = c;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        k = sb_q.size();
        while (k > 0 && sb_q[k-1].cyc > c) k--;
        sb_q.insert(k, e);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() > 0 && k < 500) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sb_q.size() > 0) begin
            chk("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    // Scoreboard: compare every expectation due at this edge index.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.cyc < cyc) chk({e.tag, "_missed"}, cyc, e.cyc);
            else             chk(e.tag, obs(e.sel), e.val);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, e1, r, cnt, tgt;
        rst_n   = 1'b0;
        i       = 1'b1;
        rst_n_s = 1'b0;
        i_s     = 1'b0;

        // 1: reset with i high, then fade in to ON.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("rst_level", int'(level), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_o", int'(o), 0);
        end
        c = cyc;
        rst_n = 1'b1;
        e1 = c + 2;
        push(e1, SEL_BUSY, 1, "up_busy_start");
        push(e1, SEL_LEVEL, 0, "up_level_start");
        for (int k = 1; k <= 15; k++) begin
            push(e1 + 2*k - 1, SEL_LEVEL, k - 1, "up_level_hold");
            push(e1 + 2*k, SEL_LEVEL, k, "up_level_step");
        end
        push(e1 + 29, SEL_BUSY, 1, "up_busy_late");
        push(e1 + 30, SEL_BUSY, 0, "up_busy_done");
        for (int t = e1 + 31; t <= e1 + 50; t++) push(t, SEL_O, 1, "on_o_high");
        drain();

        // 2: fade out from ON.
        @(negedge clk);
        c = cyc;
        i = 1'b0;
        e1 = c + 2;
        push(e1, SEL_BUSY, 1, "dn_busy_start");
        push(e1, SEL_LEVEL, 15, "dn_level_start");
        for (int k = 1; k <= 15; k++) begin
            push(e1 + 2*k - 1, SEL_LEVEL, 16 - k, "dn_level_hold");
            push(e1 + 2*k, SEL_LEVEL, 15 - k, "dn_level_step");
        end
        push(e1 + 30, SEL_BUSY, 0, "dn_busy_done");
        for (int t = e1 + 32; t <= e1 + 52; t++) push(t, SEL_O, 0, "off_o_low");
        drain();

        // 3: reversal while ramping up; the level must not jump.
        @(negedge clk);
        c = cyc;
        i = 1'b1;
        e1 = c + 2;
        for (int k = 1; k <= 6; k++) push(e1 + 2*k, SEL_LEVEL, k, "rev_up_level");
        repeat (13) @(negedge clk);
        i = 1'b0;
        r = c + 15;
        push(r, SEL_BUSY, 1, "rev_busy");
        for (int k = 0; k <= 6; k++) push(r + 2*k, SEL_LEVEL, 6 - k, "rev_dn_level");
        for (int k = 1; k <= 6; k++) push(r + 2*k - 1, SEL_LEVEL, 7 - k, "rev_dn_hold");
        push(r + 11, SEL_BUSY, 1, "rev_busy_late");
        push(r + 12, SEL_BUSY, 0, "rev_busy_done");
        drain();

        // 4: one-cycle pulse from OFF.
        @(negedge clk);
        c = cyc;
        i = 1'b1;
        push(c + 2, SEL_BUSY, 1, "pulse_busy");
        for (int t = c + 2; t <= c + 20; t++) begin
            push(t, SEL_LEVEL, 0, "pulse_level");
            push(t, SEL_O, 0, "pulse_o");
        end
        for (int t = c + 10; t <= c + 20; t++) push(t, SEL_BUSY, 0, "pulse_busy_clr");
        @(negedge clk);
        i = 1'b0;
        drain();

        // 6: asynchronous reset in the middle of a falling ramp.
        @(negedge clk);
        i = 1'b1;
        repeat (40) @(negedge clk);
        c = cyc;
        i = 1'b0;
        push(c + 2, SEL_BUSY, 1, "mid_busy");
        push(c + 2, SEL_LEVEL, 15, "mid_level_a");
        push(c + 6, SEL_LEVEL, 13, "mid_level_b");
        drain();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", int'(level), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_o", int'(o), 0);
        repeat (3) @(negedge clk);
        c = cyc;
        rst_n = 1'b1;
        for (int t = c + 1; t <= c + 20; t++) begin
            push(t, SEL_LEVEL, 0, "post_rst_level");
            push(t, SEL_BUSY, 0, "post_rst_busy");
            push(t, SEL_O, 0, "post_rst_o");
        end
        drain();

        // 5: duty measurement on the slow instance at a held level.
`ifdef LED_FADE_GAMMA_EN
        tgt = 8;
`else
        tgt = 4;
`endif
        @(negedge clk);
        c = cyc;
        rst_n_s = 1'b1;
        i_s = 1'b1;
        e1 = c + 2;
        while (cyc < e1 + 64*tgt + 4) @(negedge clk);
        chk("slow_level", int'(level_s), tgt);
        chk("slow_busy", int'(busy_s), 1);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (o_s) cnt++;
            @(negedge clk);
        end
        chk("slow_duty", cnt, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
